// File: rtl/cache_op_ctrl.sv
// Operation controller for the key/value cache: handshake, lookup wait, slot decision, strobe, response.
// Optional round-robin eviction on full CREATE when CTRL_EVICT_EN is defined.
module cache_op_ctrl #(
   parameter int NUM_ENTRIES = 16,
   parameter int IDX_W       = $clog2(NUM_ENTRIES),
   parameter int LOOKUP_LAT  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [2:0]             op_code,
   input  logic [NUM_ENTRIES-1:0] hit_in,
   input  logic [NUM_ENTRIES-1:0] used_in,
   output logic [NUM_ENTRIES-1:0] idx_out,
   output logic                   write_out,
   output logic                   select_out,
   output logic                   clear_out,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [1:0]             resp_err,
   output logic [IDX_W-1:0]       resp_idx,
   output logic                   resp_evict
);

   localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
   localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(LOOKUP_LAT - 1);
   localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
   localparam logic [NUM_ENTRIES-1:0] OH_ZERO  = {NUM_ENTRIES{1'b0}};
   localparam logic [NUM_ENTRIES-1:0] OH_ONE   = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]       IDX_ZERO = {IDX_W{1'b0}};

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_EXEC   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [2:0] OP_READ   = 3'd1;
   localparam logic [2:0] OP_CREATE = 3'd2;
   localparam logic [2:0] OP_UPDATE = 3'd3;
   localparam logic [2:0] OP_DELETE = 3'd4;

   localparam logic [1:0] ERR_OK     = 2'd0;
   localparam logic [1:0] ERR_MISS   = 2'd1;
   localparam logic [1:0] ERR_FULL   = 2'd2;
   localparam logic [1:0] ERR_EXISTS = 2'd3;

   function automatic logic [IDX_W-1:0] f_lowest_set(input logic [NUM_ENTRIES-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = IDX_ZERO;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         idx = v[i] ? IDX_W'(i) : idx;
      end
      return idx;
   endfunction

   logic [1:0]             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [2:0]             r_op;
   logic                   r_op_ready;
   logic [NUM_ENTRIES-1:0] r_idx_out;
   logic                   r_write;
   logic                   r_select;
   logic                   r_clear;
   logic                   r_resp_valid;
   logic [1:0]             r_resp_err;
   logic [IDX_W-1:0]       r_resp_idx;
   logic                   r_resp_evict;
   logic [1:0]             r_dec_err;
   logic [IDX_W-1:0]       r_dec_idx;
   logic                   r_dec_evict;

   logic                   w_hit_any;
   logic                   w_has_free;
   logic [IDX_W-1:0]       w_hit_idx;
   logic [IDX_W-1:0]       w_free_idx;
   logic                   w_wr;
   logic                   w_sel;
   logic                   w_clr;
   logic [IDX_W-1:0]       w_idx;
   logic [1:0]             w_err;
   logic                   w_evict;
   logic                   w_op_ok;
`ifdef CTRL_EVICT_EN
   localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_ENTRIES - 1);
   localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
   logic [IDX_W-1:0]       r_rr_ptr;
   logic                   w_ptr_adv;
`endif

   assign w_hit_any  = |hit_in;
   assign w_has_free = ~(&used_in);
   assign w_hit_idx  = f_lowest_set(hit_in);
   assign w_free_idx = f_lowest_set(~used_in);
   assign w_op_ok    = (op_code >= OP_READ) && (op_code <= OP_DELETE);

   // Slot decision from the latched opcode and the current hit/used vectors
   always_comb begin
      w_wr    = 1'b0;
      w_sel   = 1'b0;
      w_clr   = 1'b0;
      w_idx   = IDX_ZERO;
      w_err   = ERR_OK;
      w_evict = 1'b0;
`ifdef CTRL_EVICT_EN
      w_ptr_adv = 1'b0;
`endif
      case (r_op)
         OP_READ: begin
            if (w_hit_any) begin
               w_sel = 1'b1;
               w_idx = w_hit_idx;
            end else begin
               w_err = ERR_MISS;
            end
         end
         OP_UPDATE: begin
            if (w_hit_any) begin
               w_wr  = 1'b1;
               w_idx = w_hit_idx;
            end else begin
               w_err = ERR_MISS;
            end
         end
         OP_DELETE: begin
            if (w_hit_any) begin
               w_clr = 1'b1;
               w_idx = w_hit_idx;
            end else begin
               w_err = ERR_MISS;
            end
         end
         OP_CREATE: begin
            if (w_hit_any) begin
               w_err = ERR_EXISTS;
            end else if (w_has_free) begin
               w_wr  = 1'b1;
               w_idx = w_free_idx;
            end else begin
`ifdef CTRL_EVICT_EN
               w_wr      = 1'b1;
               w_idx     = r_rr_ptr;
               w_evict   = 1'b1;
               w_ptr_adv = 1'b1;
`else
               w_err = ERR_FULL;
`endif
            end
         end
         default: begin
            w_err = ERR_OK;
         end
      endcase
   end

   // Control FSM with registered strobes and response fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= {CNT_W{1'b0}};
         r_op         <= 3'd0;
         r_op_ready   <= 1'b1;
         r_idx_out    <= OH_ZERO;
         r_write      <= 1'b0;
         r_select     <= 1'b0;
         r_clear      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= ERR_OK;
         r_resp_idx   <= IDX_ZERO;
         r_resp_evict <= 1'b0;
         r_dec_err    <= ERR_OK;
         r_dec_idx    <= IDX_ZERO;
         r_dec_evict  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (op_valid && r_op_ready && w_op_ok) begin
                  r_op       <= op_code;
                  r_cnt      <= {CNT_W{1'b0}};
                  r_op_ready <= 1'b0;
                  r_state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (r_cnt == CNT_LAST) begin
                  r_write     <= w_wr;
                  r_select    <= w_sel;
                  r_clear     <= w_clr;
                  r_idx_out   <= (w_wr || w_sel || w_clr) ? (OH_ONE << w_idx) : OH_ZERO;
                  r_dec_err   <= w_err;
                  r_dec_idx   <= w_idx;
                  r_dec_evict <= w_evict;
                  r_state     <= S_EXEC;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_EXEC: begin
               r_write      <= 1'b0;
               r_select     <= 1'b0;
               r_clear      <= 1'b0;
               r_idx_out    <= OH_ZERO;
               r_resp_valid <= 1'b1;
               r_resp_err   <= r_dec_err;
               r_resp_idx   <= r_dec_idx;
               r_resp_evict <= r_dec_evict;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_resp_err   <= ERR_OK;
                  r_resp_idx   <= IDX_ZERO;
                  r_resp_evict <= 1'b0;
                  r_op_ready   <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_op_ready   <= 1'b1;
               r_idx_out    <= OH_ZERO;
               r_write      <= 1'b0;
               r_select     <= 1'b0;
               r_clear      <= 1'b0;
               r_resp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef CTRL_EVICT_EN
   // Round-robin victim pointer, advanced only by an evicting CREATE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= IDX_ZERO;
      end else if ((r_state == S_LOOKUP) && (r_cnt == CNT_LAST) && w_ptr_adv) begin
         r_rr_ptr <= (r_rr_ptr == PTR_LAST) ? IDX_ZERO : (r_rr_ptr + PTR_ONE);
      end
   end
`endif

   assign op_ready   = r_op_ready;
   assign idx_out    = r_idx_out;
   assign write_out  = r_write;
   assign select_out = r_select;
   assign clear_out  = r_clear;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_idx   = r_resp_idx;
   assign resp_evict = r_resp_evict;

endmodule

// File: tb/tb_cache_op_ctrl.sv
// Directed bench for cache_op_ctrl: LOOKUP_LAT=1 instance with a response scoreboard,
// plus a LOOKUP_LAT=3 instance for sampling-cycle and reset-abort checks.
module tb_cache_op_ctrl;

   typedef struct packed {
      logic [1:0] err;
      logic [3:0] idx;
      logic       evict;
   } resp_t;

   logic        clk;
   logic        rst_n;
   logic        op_valid, op_ready, write_out, select_out, clear_out, resp_valid, resp_ready, resp_evict;
   logic [2:0]  op_code;
   logic [15:0] hit_in, used_in, idx_out;
   logic [1:0]  resp_err;
   logic [3:0]  resp_idx;

   logic        op_valid_3, op_ready_3, write_out_3, select_out_3, clear_out_3, resp_valid_3, resp_ready_3, resp_evict_3;
   logic [2:0]  op_code_3;
   logic [15:0] hit_in_3, used_in_3, idx_out_3;
   logic [1:0]  resp_err_3;
   logic [3:0]  resp_idx_3;

   int    n_checks = 0;
   int    n_fail   = 0;
   resp_t sb_q[$];

   cache_op_ctrl #(.NUM_ENTRIES(16), .LOOKUP_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .hit_in(hit_in), .used_in(used_in), .idx_out(idx_out), .write_out(write_out),
      .select_out(select_out), .clear_out(clear_out), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_err(resp_err), .resp_idx(resp_idx), .resp_evict(resp_evict)
   );

   cache_op_ctrl #(.NUM_ENTRIES(16), .LOOKUP_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid_3), .op_ready(op_ready_3), .op_code(op_code_3),
      .hit_in(hit_in_3), .used_in(used_in_3), .idx_out(idx_out_3), .write_out(write_out_3),
      .select_out(select_out_3), .clear_out(clear_out_3), .resp_valid(resp_valid_3),
      .resp_ready(resp_ready_3), .resp_err(resp_err_3), .resp_idx(resp_idx_3), .resp_evict(resp_evict_3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete op on the LOOKUP_LAT=1 instance; strb is {write,select,clear}
   task automatic op1(input string tag, input logic [2:0] op, input logic [15:0] hit, input logic [15:0] used,
                      input logic [2:0] strb, input logic [15:0] oh,
                      input logic [1:0] err, input logic [3:0] idx, input logic ev);
      resp_t e;
      resp_t got;
      @(negedge clk);
      chk({tag, ".op_ready_idle"}, {31'd0, op_ready}, 32'd1);
      chk({tag, ".resp_idle"}, {31'd0, resp_valid}, 32'd0);
      op_valid = 1'b1; op_code = op; hit_in = hit; used_in = used;
      e.err = err; e.idx = idx; e.evict = ev;
      sb_q.push_back(e);
      @(negedge clk);
      op_valid = 1'b0; op_code = 3'd0;
      chk({tag, ".op_ready_busy"}, {31'd0, op_ready}, 32'd0);
      @(negedge clk);
      hit_in = ~hit; used_in = ~used;
      chk({tag, ".strobe"}, {29'd0, write_out, select_out, clear_out}, {29'd0, strb});
      chk({tag, ".idx_out"}, {16'd0, idx_out}, {16'd0, oh});
      chk({tag, ".resp_early"}, {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, ".strobe_off"}, {29'd0, write_out, select_out, clear_out}, 32'd0);
      got = {resp_err, resp_idx, resp_evict};
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, ".resp"}, {25'd0, got}, {25'd0, e});
      end else begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      resp_t       e;
      logic [15:0] oh;
      rst_n = 1'b0; resp_ready = 1'b1; resp_ready_3 = 1'b1;
      op_valid = 1'b0; op_code = 3'd0; hit_in = 16'h0000; used_in = 16'h0000;
      op_valid_3 = 1'b0; op_code_3 = 3'd0; hit_in_3 = 16'h0000; used_in_3 = 16'h0000;
      #23;
      chk("reset.op_ready", {31'd0, op_ready}, 32'd1);
      chk("reset.outs", {idx_out, 8'd0, write_out, select_out, clear_out, resp_valid, resp_err, resp_evict, 1'b0},
          32'd0);
      chk("reset.resp_idx", {28'd0, resp_idx}, 32'd0);
      chk("reset3.op_ready", {31'd0, op_ready_3}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      op1("read_hit", 3'd1, 16'h0020, 16'h0020, 3'b010, 16'h0020, 2'd0, 4'd5, 1'b0);
      op1("create_free", 3'd2, 16'h0000, 16'h00FF, 3'b100, 16'h0100, 2'd0, 4'd8, 1'b0);
      op1("create_exists", 3'd2, 16'h0004, 16'h00FF, 3'b000, 16'h0000, 2'd3, 4'd0, 1'b0);
      op1("update_miss", 3'd3, 16'h0000, 16'h00FF, 3'b000, 16'h0000, 2'd1, 4'd0, 1'b0);
      op1("delete_miss", 3'd4, 16'h0000, 16'h00FF, 3'b000, 16'h0000, 2'd1, 4'd0, 1'b0);
      op1("delete_hit", 3'd4, 16'h8001, 16'hFFFF, 3'b001, 16'h0001, 2'd0, 4'd0, 1'b0);
      op1("update_hit", 3'd3, 16'h0C00, 16'hFFFF, 3'b100, 16'h0400, 2'd0, 4'd10, 1'b0);
      for (int k = 0; k < 3; k++) begin
`ifdef CTRL_EVICT_EN
         oh = 16'h0001 << k;
         op1("create_evict", 3'd2, 16'h0000, 16'hFFFF, 3'b100, oh, 2'd0, 4'(k), 1'b1);
`else
         oh = 16'h0000;
         op1("create_full", 3'd2, 16'h0000, 16'hFFFF, 3'b000, oh, 2'd2, 4'd0, 1'b0);
`endif
      end

      // Response backpressure with a pending op on the request side
      @(negedge clk);
      resp_ready = 1'b0;
      op_valid = 1'b1; op_code = 3'd1; hit_in = 16'h0010; used_in = 16'h0000;
      e.err = 2'd0; e.idx = 4'd4; e.evict = 1'b0;
      sb_q.push_back(e);
      @(negedge clk);
      @(negedge clk);
      chk("stall.strobe", {29'd0, write_out, select_out, clear_out}, 32'd2);
      chk("stall.idx_out", {16'd0, idx_out}, 32'h0010);
      @(negedge clk);
      e = sb_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         chk("stall.resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall.resp", {25'd0, resp_err, resp_idx, resp_evict}, {25'd0, e});
         chk("stall.op_ready", {31'd0, op_ready}, 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1; op_valid = 1'b0; op_code = 3'd0;
      @(negedge clk);
      chk("stall.op_ready_after", {31'd0, op_ready}, 32'd1);
      chk("stall.resp_done", {31'd0, resp_valid}, 32'd0);

      // NOP and a reserved code are swallowed
      op_valid = 1'b1; op_code = 3'd0;
      @(negedge clk);
      op_code = 3'd6;
      @(negedge clk);
      op_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("nop.op_ready", {31'd0, op_ready}, 32'd1);
         chk("nop.quiet", {29'd0, write_out | select_out | clear_out, resp_valid, 1'b0}, 32'd0);
         @(negedge clk);
      end
      chk("sb.drained", sb_q.size(), 32'd0);

      // LOOKUP_LAT=3: only the last lookup cycle is sampled
      op_valid_3 = 1'b1; op_code_3 = 3'd1; hit_in_3 = 16'h0001;
      @(negedge clk);
      op_valid_3 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      hit_in_3 = 16'h0010;
      @(negedge clk);
      hit_in_3 = 16'h0001;
      chk("lat3.select", {31'd0, select_out_3}, 32'd1);
      chk("lat3.idx_out", {16'd0, idx_out_3}, 32'h0010);
      @(negedge clk);
      chk("lat3.resp_valid", {31'd0, resp_valid_3}, 32'd1);
      chk("lat3.resp", {26'd0, resp_err_3, resp_idx_3}, 32'h04);
      @(negedge clk);

      // Reset during LOOKUP aborts the op
      op_valid_3 = 1'b1; op_code_3 = 3'd3; hit_in_3 = 16'h0002;
      @(negedge clk);
      op_valid_3 = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst3.op_ready_in_reset", {31'd0, op_ready_3}, 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst3.quiet", {29'd0, write_out_3 | select_out_3 | clear_out_3, resp_valid_3, 1'b0}, 32'd0);
         chk("rst3.op_ready", {31'd0, op_ready_3}, 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
